// File: rtl/seq_alu_if.sv
// Execute-stage ALU bus: operands, opcode and request from the control unit;
// result, flags and the start/busy/done handshake back from the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  // Handshake: a request is taken on a rising edge where start=1 and busy=0.
  // Each accepted request yields exactly one done pulse. R/Z/V are valid in
  // that cycle and hold until the next done. start with busy=1 is dropped.
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [2:0]       Aluc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic             Z;
  logic             V;
  logic             state;

  modport master (output start, X, Y, Aluc, input busy, done, R, Z, V, state);
  modport slave  (input start, X, Y, Aluc, output busy, done, R, Z, V, state);
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ADD/SUB/AND/OR/XOR/SLT, plus an iterative
// shift-add unsigned multiply that returns either half of the product.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      clrn,
  seq_alu_if.slave bus
);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mul_hi;
  logic [WIDTH-1:0] r_q;
  logic             z_q;
  logic             v_q;
  logic             done_q;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;
  logic             accept;

  // One shift-add step; after the last step {acc, mplier} holds the product.
  always_comb begin
    step_sum   = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt    = step_sum[WIDTH:1];
    mplier_nxt = {step_sum[0], mplier[WIDTH-1:1]};
    mul_res    = mul_hi ? acc_nxt : mplier_nxt;
  end

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (bus.Aluc)
      3'b000: begin
        alu_r = bus.X + bus.Y;
        alu_v = (bus.X[MSB] == bus.Y[MSB]) && (alu_r[MSB] != bus.X[MSB]);
      end
      3'b001: begin
        alu_r = bus.X - bus.Y;
        alu_v = (bus.X[MSB] != bus.Y[MSB]) && (alu_r[MSB] != bus.X[MSB]);
      end
      3'b010:  alu_r = bus.X & bus.Y;
      3'b011:  alu_r = bus.X | bus.Y;
      3'b100:  alu_r = bus.X ^ bus.Y;
      3'b101:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.X) < $signed(bus.Y))};
      default: alu_r = '0;
    endcase
  end

  assign accept = bus.start && (state == S_IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_hi <= 1'b0;
      r_q    <= '0;
      z_q    <= 1'b1;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          if (bus.Aluc[2:1] != 2'b11) begin
            r_q    <= alu_r;
            z_q    <= ~|alu_r;
            v_q    <= alu_v;
            done_q <= 1'b1;
          end else begin
            mcand  <= bus.X;
            mplier <= bus.Y;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            mul_hi <= bus.Aluc[0];
            state  <= S_MUL;
          end
        end
      end else begin
        acc    <= acc_nxt;
        mplier <= mplier_nxt;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          r_q    <= mul_res;
          z_q    <= ~|mul_res;
          v_q    <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
      end
    end
  end

  assign bus.busy  = (state == S_MUL);
  assign bus.done  = done_q;
  assign bus.R     = r_q;
  assign bus.Z     = z_q;
  assign bus.V     = v_q;
  assign bus.state = state;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: random and directed requests, a high-level arithmetic
// reference model, and a scoreboard that checks result timing and values.
module tb_seq_alu;
  localparam int WIDTH = 32;
  localparam int EW    = 32 + WIDTH + 2;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // {due cycle, R, Z, V}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer arithmetic
  function automatic void model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y,
                                output logic [WIDTH-1:0] r, output logic v);
    longint sx, sy, s, max_s, min_s;
    logic [2*WIDTH-1:0] p;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    max_s = (longint'(1) <<< (WIDTH - 1)) - 1;
    min_s = -(longint'(1) <<< (WIDTH - 1));
    p     = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    v     = 1'b0;
    s     = 0;
    r     = '0;
    case (op)
      3'd0: begin s = sx + sy; r = WIDTH'(s); v = (s > max_s) || (s < min_s); end
      3'd1: begin s = sx - sy; r = WIDTH'(s); v = (s > max_s) || (s < min_s); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sx < sy) ? WIDTH'(1) : WIDTH'(0);
      3'd6: r = p[WIDTH-1:0];
      default: r = p[2*WIDTH-1:WIDTH];
    endcase
  endfunction

  // Driver: waits for busy=0, presents one request for one edge
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input bit count_busy);
    logic [WIDTH-1:0] r;
    logic v;
    int budget;
    int lat;
    int bn;
    budget = 0;
    while (bus.busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (bus.busy) check("issue_busy_timeout", 64'(bus.busy), 64'd0);
    model(op, x, y, r, v);
    lat = (op[2:1] == 2'b11) ? WIDTH : 0;
    bus.start = 1'b1;
    bus.Aluc  = op;
    bus.X     = x;
    bus.Y     = y;
    exp_q.push_back({32'(cyc + 1 + lat), r, ~|r, v});
    @(negedge clk);
    bus.start = 1'b0;
    if (count_busy && lat != 0) begin
      bn = 0;
      while (bus.busy && bn < WIDTH + 10) begin
        bn++;
        @(negedge clk);
      end
      check("busy_cycles", 64'(bn), 64'(WIDTH));
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (clrn) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("R", 64'(bus.R), 64'(e[WIDTH+1:2]));
          check("Z", 64'(bus.Z), 64'(e[1]));
          check("V", 64'(bus.V), 64'(e[0]));
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (32'(cyc) >= e[EW-1 -: 32]) begin
          e = exp_q.pop_front();
          check("missing_done", 64'd0, 64'd1);
        end
      end
    end
  end

  logic [WIDTH-1:0] specials [5];

  function automatic logic [WIDTH-1:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return WIDTH'($urandom);
  endfunction

  initial begin
    int budget;
    specials[0] = '0;
    specials[1] = WIDTH'(1);
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;
    bus.start = 1'b0;
    bus.Aluc  = 3'd0;
    bus.X     = '0;
    bus.Y     = '0;

    #13;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_R", 64'(bus.R), 64'd0);
    check("rst_Z", 64'(bus.Z), 64'd1);
    check("rst_V", 64'(bus.V), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // Directed boundary cases
    issue(3'd0, 32'h7FFF_FFFF, 32'h1, 0);
    issue(3'd1, 32'h5, 32'h5, 0);
    issue(3'd1, 32'h8000_0000, 32'h1, 0);
    issue(3'd5, 32'hFFFF_FFFF, 32'h1, 0);
    issue(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'h0001_0000, 32'h0001_0000, 1);

    // start during a multiply must be dropped
    issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.Aluc  = 3'd0;
    bus.X     = 32'h2;
    bus.Y     = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    issue(3'd0, 32'h2, 32'h3, 0);
    issue(3'd0, 32'h2, 32'h3, 0);

    // Random traffic, back-to-back where possible
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 0);
    end

    // Asynchronous reset in the middle of a multiply
    issue(3'd6, 32'hDEAD_BEEF, 32'h0000_0013, 0);
    repeat (9) @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_R", 64'(bus.R), 64'd0);
    check("arst_Z", 64'(bus.Z), 64'd1);
    check("arst_V", 64'(bus.V), 64'd0);
    check("arst_state", 64'(bus.state), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    issue(3'd6, 32'h3, 32'h7, 1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
